// File: rtl/adc_pkg.sv
// Shared constants and helpers for the ADC averaging register.
// Build option: define ADC_AVG_ROUND_EN to round-half-up the averaged result
// (with saturation) instead of truncating it.
package adc_pkg;

  localparam int ADC_R       = 12;
  localparam int ADC_W       = 8;
  localparam int ADC_CH      = 4;
  localparam int ADC_LOG_AVG = 2;

  // Ceiling log2 for elaboration-time sizing; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Channel-select width: never narrower than one bit.
  function automatic int chw_of(input int ch);
    return (clog2(ch) < 1) ? 1 : clog2(ch);
  endfunction

endpackage

// File: rtl/adc_avg_channel.sv
// One averaging channel: accumulates 2^LOG_AVG samples, then loads the
// width-reduced block sum into its output register and pulses valid.
// Build option: ADC_AVG_ROUND_EN selects round-half-up with saturation.
module adc_avg_channel #(
  parameter int R       = 12,
  parameter int W       = 8,
  parameter int LOG_AVG = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [R-1:0] a,
  output logic [W-1:0] y,
  output logic         valid
);

  localparam int AW = R + LOG_AVG;
  localparam int S  = AW - W;

  logic [AW-1:0] acc_reg;
  logic [AW-1:0] sum;
  logic [W-1:0]  y_reg;
  logic          valid_reg;
  logic          last;
  logic [W-1:0]  result;

  // The accumulator is wide enough for a full block of max-scale samples.
  assign sum = acc_reg + AW'(a);

  generate
    if (LOG_AVG > 0) begin : g_cnt
      logic [LOG_AVG-1:0] cnt_reg;

      assign last = &cnt_reg;

      // Sample counter; wraps to zero on the completing strobe.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (clr) begin
          cnt_reg <= '0;
        end else if (en) begin
          cnt_reg <= cnt_reg + LOG_AVG'(1);
        end
      end
    end else begin : g_nocnt
      // Without averaging every strobe completes a block.
      assign last = 1'b1;
    end
  endgenerate

`ifdef ADC_AVG_ROUND_EN
  generate
    if (S == 0) begin : g_rnd_none
      assign result = W'(sum);
    end else begin : g_rnd
      logic [AW:0] rsum;
      logic [AW:0] rshift;

      // Add half an output LSB, then clamp the single possible carry-out.
      assign rsum   = {1'b0, sum} + ((AW + 1)'(1) << (S - 1));
      assign rshift = rsum >> S;
      assign result = (rshift > (AW + 1)'((1 << W) - 1)) ? {W{1'b1}} : W'(rshift);
    end
  endgenerate
`else
  assign result = W'(sum >> S);
`endif

  // Accumulate, or on the last sample of a block publish the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      y_reg     <= '0;
      valid_reg <= 1'b0;
    end else if (clr) begin
      acc_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (en) begin
      if (last) begin
        y_reg     <= result;
        acc_reg   <= '0;
        valid_reg <= 1'b1;
      end else begin
        acc_reg   <= sum;
        valid_reg <= 1'b0;
      end
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign y     = y_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/adc_avg_reg.sv
// Multi-channel ADC sample register with per-channel block averaging.
// The top level only decodes the strobe to a channel; all state lives in
// adc_avg_channel. Build option: ADC_AVG_ROUND_EN (rounded result).
module adc_avg_reg
  import adc_pkg::*;
#(
  parameter int R       = ADC_R,
  parameter int W       = ADC_W,
  parameter int CH      = ADC_CH,
  parameter int LOG_AVG = ADC_LOG_AVG,
  localparam int CHW    = chw_of(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_en,
  input  logic [CHW-1:0]  sample_ch,
  input  logic [R-1:0]    A,
  input  logic            clr,
  output logic [CH*W-1:0] Y,
  output logic [CH-1:0]   valid
);

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic hit;

      // Out-of-range channel numbers match no instance and are dropped.
      assign hit = sample_en && (sample_ch == CHW'(gi)) && !clr;

      adc_avg_channel #(
        .R       (R),
        .W       (W),
        .LOG_AVG (LOG_AVG)
      ) u_channel (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (hit),
        .a     (A),
        .y     (Y[gi*W +: W]),
        .valid (valid[gi])
      );
    end
  endgenerate

endmodule
